alu_op_loader: RTL and testbench

Operand/opcode loading controller for the 6-bit board ALU. It takes the shared switch bus and three push-buttons and loads Data_A, Data_B and Op in a fixed order. It then waits for the ALU result, latches it onto the LEDs and flags it valid. It sits between the board I/O and the ALU instance, and it is the only writer of the ALU's operand and opcode inputs.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_loader_if.sv | 31 +++
 rtl/alu_op_loader_btn_conditioner.sv | 49 ++++
 rtl/alu_op_loader.sv | 133 +++++++++++++
 tb/tb_alu_op_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the board ALU loader: funct codes, FSM encodings and the
// opcode legality check used when ALU_OP_LOADER_OPCHECK_EN is defined.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  function automatic logic is_supported_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_supported_op = 1'b1;
      default:                        is_supported_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_loader_if.sv
// Board-side and ALU-side signal bundle of the operand/opcode loader.
// The slave modport is the loader's view; the master modport drives switches, buttons and the ALU result.
interface alu_op_loader_if #(
  parameter int NB_DATA = 6,
  parameter int NB_OP   = 6
);

  logic [NB_DATA-1:0] Switches;
  logic               Btn_A;
  logic               Btn_B;
  logic               Btn_Op;
  logic [NB_DATA-1:0] Alu_Result;
  logic [NB_DATA-1:0] Data_A;
  logic [NB_DATA-1:0] Data_B;
  logic [NB_OP-1:0]   Op;
  logic [NB_DATA-1:0] LEDS;
  logic               Valid;
  logic               Error;
  logic [2:0]         State;

  modport master (
    output Switches, Btn_A, Btn_B, Btn_Op, Alu_Result,
    input  Data_A, Data_B, Op, LEDS, Valid, Error, State
  );

  modport slave (
    input  Switches, Btn_A, Btn_B, Btn_Op, Alu_Result,
    output Data_A, Data_B, Op, LEDS, Valid, Error, State
  );

endinterface

// File: rtl/alu_op_loader_btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, saturating debounce counter and a
// single-cycle press pulse that fires once per press, however long the button is held.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronized level stays high, so it rearms on release.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  // High during the last of DEBOUNCE_CYCLES high cycles; the counter then saturates past it.
  assign press = sync2_q && (cnt_q == CNT_FIRE);

endmodule

// File: rtl/alu_op_loader.sv
// Loads Data_A, Data_B and Op from the shared switches in fixed order, waits for the ALU and latches LEDS.
// Define ALU_OP_LOADER_OPCHECK_EN to reject unsupported opcodes via Error.
module alu_op_loader
  import alu_pkg::*;
#(
  parameter int NB_DATA         = 6,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LATENCY     = 1
) (
  input logic             clock,
  input logic             reset,
  alu_op_loader_if.slave  bus
);

  localparam int                WAIT_W    = $clog2(ALU_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_LATENCY - 1);

  logic press_a_s, press_b_s, press_op_s;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] leds_q, leds_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_a (
    .clock(clock), .reset(reset), .btn_raw(bus.Btn_A), .press(press_a_s)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_b (
    .clock(clock), .reset(reset), .btn_raw(bus.Btn_B), .press(press_b_s)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_op (
    .clock(clock), .reset(reset), .btn_raw(bus.Btn_Op), .press(press_op_s)
  );

  // Next-state and register updates; presses not matching the state are simply dropped.
  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    leds_d   = leds_q;
    valid_d  = valid_q;
    error_d  = error_q;
    wait_d   = '0;
    case (state_q)
      ST_LOAD_A, ST_SHOW: begin
        if (press_a_s) begin
          data_a_d = bus.Switches;
          valid_d  = 1'b0;
          state_d  = ST_LOAD_B;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_B: begin
        if (press_b_s) begin
          data_b_d = bus.Switches;
          state_d  = ST_LOAD_OP;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_OP: begin
        if (press_op_s) begin
          op_d = bus.Switches[NB_OP-1:0];
`ifdef ALU_OP_LOADER_OPCHECK_EN
          if (is_supported_op(OP_W'(bus.Switches[NB_OP-1:0]))) begin
            error_d = 1'b0;
            state_d = ST_EXEC;
          end else begin
            error_d = 1'b1;
            state_d = ST_LOAD_OP;
          end
`else
          error_d = 1'b0;
          state_d = ST_EXEC;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_EXEC: begin
        if (wait_q == WAIT_LAST) begin
          leds_d  = bus.Alu_Result;
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOAD_A;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD_A;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      leds_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      leds_q   <= leds_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      wait_q   <= wait_d;
    end
  end

  assign bus.Data_A = data_a_q;
  assign bus.Data_B = data_b_q;
  assign bus.Op     = op_q;
  assign bus.LEDS   = leds_q;
  assign bus.Valid  = valid_q;
  assign bus.Error  = error_q;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_alu_op_loader.sv
// Scoreboard bench for alu_op_loader: every press pushes the expected output changes with
// the cycle they must appear on; a negedge monitor pops and compares each observed change.
module tb_alu_op_loader;

  localparam int D = 4;
  localparam int L = 3;
  localparam logic [5:0] CODES [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                       6'b100110, 6'b100111, 6'b000011, 6'b000010};

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    logic [5:0] leds;
    logic       valid;
    logic       err;
    logic [2:0] st;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_c = 0;
  exp_t  q[$];
  snap_t m = '0;
  snap_t prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_loader_if #(.NB_DATA(6), .NB_OP(6)) bus ();

  alu_op_loader #(.NB_DATA(6), .NB_OP(6), .DEBOUNCE_CYCLES(D), .ALU_LATENCY(L)) dut (
    .clock(clk), .reset(reset), .bus(bus)
  );

  function automatic logic [5:0] alu_fn(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
    case (op)
      6'b100000: alu_fn = a + b;
      6'b100010: alu_fn = a - b;
      6'b100100: alu_fn = a & b;
      6'b100101: alu_fn = a | b;
      6'b100110: alu_fn = a ^ b;
      6'b100111: alu_fn = ~(a | b);
      6'b000011: alu_fn = 6'($signed(a) >>> b);
      6'b000010: alu_fn = a >> b;
      default:   alu_fn = 6'h00;
    endcase
  endfunction

  assign bus.Alu_Result = alu_fn(bus.Data_A, bus.Data_B, bus.Op);

  function automatic bit supported(input logic [5:0] op);
`ifdef ALU_OP_LOADER_OPCHECK_EN
    for (int i = 0; i < 8; i++) if (CODES[i] == op) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic snap_t dut_snap();
    return {bus.Data_A, bus.Data_B, bus.Op, bus.LEDS, bus.Valid, bus.Error, bus.State};
  endfunction

  // Reference model: a press held >= D cycles acts at cycle c+2+D; only the expected button counts.
  task automatic model_press(input logic [2:0] mask, input logic [5:0] sw, input int hold,
                             input int c, input bit inhibit_show);
    snap_t n, n2;
    int t;
    if (hold < D) return;
    t = c + 2 + D;
    n = m;
    if ((m.st == 3'd0 || m.st == 3'd4) && mask[0]) begin
      n.a = sw; n.valid = 1'b0; n.st = 3'd1;
    end else if (m.st == 3'd1 && mask[1]) begin
      n.b = sw; n.st = 3'd2;
    end else if (m.st == 3'd2 && mask[2]) begin
      n.op = sw;
      if (supported(sw)) begin
        n.err = 1'b0; n.st = 3'd3;
      end else begin
        n.err = 1'b1;
      end
    end
    if (n != m) q.push_back('{t, n});
    m = n;
    if (n.st == 3'd3 && !inhibit_show) begin
      n2 = n;
      n2.leds  = alu_fn(n.a, n.b, n.op);
      n2.valid = 1'b1;
      n2.st    = 3'd4;
      q.push_back('{t + L, n2});
      m = n2;
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [5:0] sw, input int hold,
                       input bit inhibit_show = 1'b0);
    @(negedge clk);
    bus.Switches = sw;
    {bus.Btn_Op, bus.Btn_B, bus.Btn_A} = mask;
    last_c = cyc;
    model_press(mask, sw, hold, cyc, inhibit_show);
    repeat (hold) @(negedge clk);
    {bus.Btn_Op, bus.Btn_B, bus.Btn_A} = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_now(input string name);
    snap_t cur;
    cur = dut_snap();
    vectors++;
    if (cur !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs=%h expected=%h", name, cur, snap_t'('0));
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_now(name);
    if (m != '0) q.push_back('{cyc + 1, snap_t'('0)});
    m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation and its cycle.
  always @(negedge clk) begin
    snap_t cur;
    exp_t  e;
    cur = dut_snap();
    if (cur !== prev) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: cyc=%0d got=%h prev=%h", cyc, cur, prev);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.s !== cur) begin
          miscompares++;
          $display("FAIL output_event: cyc=%0d got=%h expected cyc=%0d value=%h",
                   cyc, cur, e.cyc, e.s);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [2:0] mask;
    logic [5:0] sw;
    int E;
    bus.Switches = 6'd0;
    bus.Btn_A = 1'b0;
    bus.Btn_B = 1'b0;
    bus.Btn_Op = 1'b0;
    idle(2);
    check_reset_now("reset_state");
    reset = 1'b0;
    idle(2);

    // Out-of-order B press, then the ADD flow 15 + 20 = 35, then restart from SHOW.
    press(3'b010, 6'd33, 6);  idle(D + 4);
    press(3'b001, 6'd15, 6);  idle(D + 4);
    press(3'b010, 6'd20, 6);  idle(D + 4);
    press(3'b100, 6'b100000, 6); idle(D + 4);
    press(3'b001, 6'd20, 6);  idle(D + 4);

    // Bad opcode then AND: 15 & 20 = 4.
    do_reset("reset_before_badop");
    idle(2);
    press(3'b001, 6'd15, 6);  idle(D + 4);
    press(3'b010, 6'd20, 6);  idle(D + 4);
    press(3'b100, 6'b111111, 6); idle(D + 4);
    press(3'b100, 6'b100100, 6); idle(D + 4);

    // Bounce shorter than D, then one long press.
    do_reset("reset_before_bounce");
    idle(2);
    press(3'b001, 6'd9, 3);
    press(3'b001, 6'd9, 3);
    idle(3);
    press(3'b001, 6'd9, 10); idle(D + 4);

    // Reset during the second EXEC cycle: clears at once, nothing captured afterwards.
    press(3'b010, 6'd7, 6);   idle(D + 4);
    press(3'b100, 6'b100000, 5, 1'b1);
    E = last_c + 2 + D;
    for (int k = 0; k < 50 && cyc < E; k++) @(negedge clk);
    do_reset("reset_mid_exec");
    idle(L + 6);

    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 3) == 0) mask = 3'($urandom_range(1, 7));
      else if (m.st == 3'd1)         mask = 3'b010;
      else if (m.st == 3'd2)         mask = 3'b100;
      else                           mask = 3'b001;
      sw = 6'($urandom_range(0, 63));
      if (m.st == 3'd2 && $urandom_range(0, 2) != 0) sw = CODES[$urandom_range(0, 7)];
      press(mask, sw, $urandom_range(2, 9));
      idle(D + 4);
    end

    idle(20);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: outstanding=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
